// File: rtl/layer_scheduler.sv
// layer_scheduler: sequences the LeNet layer engines one at a time, inserts an
// idle gap between layers, watches each layer with an optional timeout, and
// steers the shared bias/weights and result BRAM ports to the active engine.
module layer_scheduler #(
    parameter int unsigned N_LAYERS       = 6,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned BW_AW          = 19,
    parameter int unsigned RS_AW          = 15,
    parameter int unsigned DW             = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [N_LAYERS-1:0]       layer_en,
    input  logic [N_LAYERS-1:0]       layer_finish,
    input  logic [N_LAYERS-1:0]       lyr_bw_ena,
    input  logic [N_LAYERS*BW_AW-1:0] lyr_bw_addra,
    input  logic [N_LAYERS-1:0]       lyr_rs_ena,
    input  logic [N_LAYERS-1:0]       lyr_rs_wea,
    input  logic [N_LAYERS*RS_AW-1:0] lyr_rs_addra,
    input  logic [N_LAYERS*DW-1:0]    lyr_rs_dina,
    output logic                      bias_weights_bram_ena,
    output logic [BW_AW-1:0]          bias_weights_bram_addra,
    output logic                      result_bram_ena,
    output logic                      result_bram_wea,
    output logic [RS_AW-1:0]          result_bram_addra,
    output logic [DW-1:0]             result_bram_dina,
    output logic [2:0]                cur_layer,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    localparam int unsigned GAP_W = 4;
    localparam int unsigned WD_W  = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0]       LAST_LAYER = 3'(N_LAYERS - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam bit               WD_ENABLE  = (TIMEOUT_CYCLES != 0);

    logic [1:0]          state_q, state_d;
    logic [N_LAYERS-1:0] layer_en_q, layer_en_d;
    logic [2:0]          cur_layer_q, cur_layer_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic                finish_c;

    // Only the enabled engine's finish flag is honoured; all others are masked.
    assign finish_c = |(layer_finish & layer_en_q);

    // Next-state logic for the layer sequencer.
    always_comb begin
        state_d     = state_q;
        layer_en_d  = layer_en_q;
        cur_layer_d = cur_layer_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        gap_cnt_d   = gap_cnt_q;
        wdog_d      = wdog_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    layer_en_d  = N_LAYERS'(1);
                    cur_layer_d = 3'd0;
                    busy_d      = 1'b1;
                    error_d     = 1'b0;
                    wdog_d      = '0;
                end
            end
            S_RUN: begin
                wdog_d = wdog_q + WD_W'(1);
                // A finish in the timeout cycle takes priority over the watchdog.
                if (finish_c) begin
                    layer_en_d = '0;
                    if (cur_layer_q == LAST_LAYER) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end else if (WD_ENABLE && (wdog_q == WD_LIMIT)) begin
                    layer_en_d = '0;
                    error_d    = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    cur_layer_d = cur_layer_q + 3'd1;
                    layer_en_d  = N_LAYERS'(1) << (cur_layer_q + 3'd1);
                    wdog_d      = '0;
                    state_d     = S_RUN;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d    = S_IDLE;
                layer_en_d = '0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            layer_en_q  <= '0;
            cur_layer_q <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            gap_cnt_q   <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            layer_en_q  <= layer_en_d;
            cur_layer_q <= cur_layer_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            gap_cnt_q   <= gap_cnt_d;
            wdog_q      <= wdog_d;
        end
    end

    // BRAM port mux: only the enabled engine reaches the BRAMs; write enable
    // is qualified by the same engine's port enable.
    always_comb begin
        bias_weights_bram_ena   = 1'b0;
        bias_weights_bram_addra = '0;
        result_bram_ena         = 1'b0;
        result_bram_wea         = 1'b0;
        result_bram_addra       = '0;
        result_bram_dina        = '0;
        for (int unsigned i = 0; i < N_LAYERS; i++) begin
            if (layer_en_q[i]) begin
                bias_weights_bram_ena   = lyr_bw_ena[i];
                bias_weights_bram_addra = lyr_bw_addra[i*BW_AW +: BW_AW];
                result_bram_ena         = lyr_rs_ena[i];
                result_bram_wea         = lyr_rs_wea[i] & lyr_rs_ena[i];
                result_bram_addra       = lyr_rs_addra[i*RS_AW +: RS_AW];
                result_bram_dina        = lyr_rs_dina[i*DW +: DW];
            end
        end
    end

    assign layer_en  = layer_en_q;
    assign cur_layer = cur_layer_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: doc/layer_scheduler.md
Name: layer_scheduler

Overview:
- Top-level sequencer for the LeNet layer engines (conv1, pool1, conv2, pool2, fc_1, fc_2).
- Enables one layer engine at a time, in order, and waits for each engine's finish flag before moving on.
- Owns the single port of the shared bias/weights BRAM and the single port of the shared result BRAM, and muxes them to the active engine.
- Adds a configurable idle gap between layers and a per-layer watchdog timeout.

Parameters:
- N_LAYERS, 6, number of layer engines, enabled in index order 0..N_LAYERS-1.
- GAP_CYCLES, 2, idle cycles between one layer's finish and the next layer's enable (range 1..15).
- TIMEOUT_CYCLES, 0, maximum RUN cycles per layer; 0 disables the watchdog. Counter is 32 bits.
- BW_AW, 19, bias/weights BRAM address width.
- RS_AW, 15, result BRAM address width.
- DW, 8, data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to run the whole network
- layer_en  out  N_LAYERS  one-hot (or zero) enable, one bit per engine
- layer_finish  in  N_LAYERS  per-engine finish flag
- lyr_bw_ena  in  N_LAYERS  per-engine bias/weights BRAM enable
- lyr_bw_addra  in  N_LAYERS*BW_AW  packed; engine i uses slice [i*BW_AW +: BW_AW]
- lyr_rs_ena  in  N_LAYERS  per-engine result BRAM enable
- lyr_rs_wea  in  N_LAYERS  per-engine result BRAM write enable
- lyr_rs_addra  in  N_LAYERS*RS_AW  packed per-engine result BRAM address
- lyr_rs_dina  in  N_LAYERS*DW  packed per-engine result BRAM write data
- bias_weights_bram_ena  out  1  to BRAM
- bias_weights_bram_addra  out  BW_AW  to BRAM
- result_bram_ena  out  1  to BRAM
- result_bram_wea  out  1  to BRAM
- result_bram_addra  out  RS_AW  to BRAM
- result_bram_dina  out  DW  to BRAM
- cur_layer  out  3  index of the active or last-active layer
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last layer completes
- error  out  1  sticky; set on watchdog timeout

Behaviour:
- Reset:
  - state=IDLE; layer_en=0, cur_layer=0, busy=0, done=0, error=0.
  - Gap counter and watchdog counter cleared.
  - rst mid-run drops layer_en in the same edge; no done pulse is produced.
- States: IDLE, RUN, GAP, DONE.
- IDLE:
  - start=1 at edge k: state=RUN, layer_en=1 (bit 0), cur_layer=0, busy=1, error cleared, watchdog=0.
- RUN:
  - Watchdog increments every cycle.
  - layer_finish[cur_layer]=1 at edge e:
    - layer_en=0 at edge e.
    - If cur_layer==N_LAYERS-1: state=DONE.
    - Otherwise: state=GAP, gap counter loaded with GAP_CYCLES-1.
  - Finish bits of non-active layers are ignored.
  - If TIMEOUT_CYCLES!=0 and watchdog reaches TIMEOUT_CYCLES-1 with no finish:
    - layer_en=0, error=1, state=IDLE, busy=0.
    - cur_layer holds the index of the failing layer.
  - A finish arriving in the same cycle as the timeout wins: the layer completes normally and no error is raised.
- GAP:
  - Gap counter decrements each cycle.
  - On the cycle the counter reads 0: cur_layer+=1, that layer's layer_en bit=1, watchdog=0, state=RUN.
  - Result: exactly GAP_CYCLES cycles with layer_en=0 between layers.
- DONE:
  - done=1 for exactly one cycle; next edge state=IDLE, busy=0, done=0.
- start is ignored in RUN, GAP and DONE.
- BRAM mux:
  - Combinational from the registered layer_en.
  - When layer_en[i]=1, all six BRAM outputs equal engine i's request signals; zero added latency.
  - When layer_en==0 (IDLE, GAP, DONE, reset): bias_weights_bram_ena, result_bram_ena and result_bram_wea are 0; addresses and data are driven 0.
  - Requests from non-enabled engines never reach the BRAMs, including stale enables left asserted after an engine finishes.
- Invariants:
  - layer_en is never multi-hot.
  - result_bram_wea=1 implies result_bram_ena=1 at the outputs; if the engine drives wea=1 with ena=0, wea is masked to 0.

Test Plan:
- Nominal run, N_LAYERS=3, GAP_CYCLES=2: start at cycle 10; each engine finishes 20 cycles after its enable.
  - layer_en goes 001 → 000 (2 cycles) → 010 → 000 → 100 → 000.
  - done pulses once; busy falls the cycle after done.
- Mux isolation: engine 1 drives addra=0x1234 with ena=1 while engine 0 is active.
  - BRAM sees only engine 0's address.
  - During GAP, BRAM enables read 0.
- Spurious finish: layer_finish[2]=1 while layer 0 is in RUN → ignored; sequence unchanged.
- Watchdog, TIMEOUT_CYCLES=50: layer 1 never finishes.
  - layer_en=0 and error=1 at RUN cycle 50, cur_layer=1, busy=0.
  - A new start clears error.
- Reset mid-run: rst during layer 1 RUN → layer_en=0, busy=0, no done; a following start runs from layer 0.
- start held high throughout a run → no restart mid-sequence; exactly one done per run.
